// File: rtl/uart_mmio_bridge.sv
// rtl/uart_mmio_bridge.sv - MMIO request/response to UART byte-register strobe bridge with paced TX FIFO
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        single-outstanding MMIO request handshake
//   req_wen/req_addr/req_wdata request type (1 = write), register offset, write byte
//   resp_valid/resp_ready      response handshake
//   resp_rdata                 read data (0 for write acks)
//   uart_wen/waddr/wdata       one-cycle write strobe to the UART register model
//   uart_ren/raddr             one-cycle read strobe to the UART register model
//   uart_rdata                 read byte, valid the cycle after uart_ren
//   tx_level                   TX FIFO occupancy
//
// Optional feature: define UART_LSR_SYNTH_EN to answer LSR_ADDR reads locally
// from FIFO/gap state instead of forwarding them to the UART model.
module uart_mmio_bridge #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TX_GAP     = 4,
    parameter logic [7:0]  THR_ADDR   = 8'h00,
    parameter logic [7:0]  LSR_ADDR   = 8'h05
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wen,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_wdata,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [7:0]                    resp_rdata,
    output logic                          uart_wen,
    output logic [7:0]                    uart_waddr,
    output logic [7:0]                    uart_wdata,
    output logic                          uart_ren,
    output logic [7:0]                    uart_raddr,
    input  logic [7:0]                    uart_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

`ifdef UART_LSR_SYNTH_EN
    localparam bit LSR_SYNTH = 1'b1;
`else
    localparam bit LSR_SYNTH = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      resp_rdata_q, resp_rdata_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            fifo_empty, fifo_full, gap_zero;
    logic            is_thr_wr, is_lsr_rd, in_idle;
    logic            accept, push, drain, direct_wr, direct_rd;
    logic [7:0]      lsr_status;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign gap_zero   = (gap_q == '0);

    assign is_thr_wr  = req_wen && (req_addr == THR_ADDR);
    assign is_lsr_rd  = LSR_SYNTH && !req_wen && (req_addr == LSR_ADDR);
    // Gating with reset keeps req_ready (and every strobe derived from it) low while reset is held.
    assign in_idle    = (state_q == IDLE) && !reset;

    // Direct UART accesses require an empty FIFO and the drain requires a
    // non-empty one, so the two can never both drive uart_wen in one cycle.
    assign drain      = !fifo_empty && gap_zero;

    always_comb begin
        req_ready = 1'b0;
        if (in_idle) begin
            if (is_thr_wr) begin
                req_ready = !fifo_full;
            end else begin
                req_ready = is_lsr_rd || fifo_empty;
            end
        end
    end

    assign accept    = req_valid && req_ready;
    assign push      = accept && is_thr_wr;
    assign direct_wr = accept && req_wen && !is_thr_wr;
    assign direct_rd = accept && !req_wen && !is_lsr_rd;

    assign lsr_status = {1'b0, fifo_empty && gap_zero, fifo_empty, 5'b0_0000};

    // UART strobes: drained THR byte or direct access; address/data forced to 0 when idle.
    always_comb begin
        uart_wen   = drain || direct_wr;
        uart_waddr = 8'h00;
        uart_wdata = 8'h00;
        if (drain) begin
            uart_waddr = THR_ADDR;
            uart_wdata = mem_q[rd_ptr_q];
        end else if (direct_wr) begin
            uart_waddr = req_addr;
            uart_wdata = req_wdata;
        end
        uart_ren   = direct_rd;
        uart_raddr = direct_rd ? req_addr : 8'h00;
    end

    // FIFO pointers, occupancy and drain pacing.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gap_d    = gap_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            gap_d    = GW'(TX_GAP);
        end else if (!gap_zero) begin
            gap_d    = gap_q - GW'(1);
        end
        case ({push, drain})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Request FSM next state and response data.
    always_comb begin
        state_d      = state_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = direct_rd ? RD_WAIT : RESP;
                    resp_rdata_d = is_lsr_rd ? lsr_status : 8'h00;
                end
            end
            RD_WAIT: begin
                state_d      = RESP;
                resp_rdata_d = uart_rdata;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            gap_q        <= '0;
            resp_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            gap_q        <= gap_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_wdata;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign tx_level   = count_q;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb/tb_uart_mmio_bridge.sv - directed self-checking bench for uart_mmio_bridge
module tb_uart_mmio_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_wen;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_rdata;
    logic       uart_wen, uart_ren;
    logic [7:0] uart_waddr, uart_wdata, uart_raddr;
    logic [7:0] uart_rdata = 8'h00;
    logic [3:0] tx_level;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    int         wen_cyc[$];
    logic [7:0] wen_addr[$];
    logic [7:0] wen_data[$];
    int         ren_cyc[$];
    int         both_cnt = 0;
    int         peak = 0;

    uart_mmio_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .uart_wen   (uart_wen),
        .uart_waddr (uart_waddr),
        .uart_wdata (uart_wdata),
        .uart_ren   (uart_ren),
        .uart_raddr (uart_raddr),
        .uart_rdata (uart_rdata),
        .tx_level   (tx_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART register model: LSR reads 0x60, anything else 0xA5, one cycle after the strobe.
    always @(posedge clk) begin
        if (uart_ren) uart_rdata <= (uart_raddr == 8'h05) ? 8'h60 : 8'hA5;
    end

    always @(negedge clk) begin
        if (uart_wen) begin
            wen_cyc.push_back(cyc);
            wen_addr.push_back(uart_waddr);
            wen_data.push_back(uart_wdata);
        end
        if (uart_ren) ren_cyc.push_back(cyc);
        if (uart_wen && uart_ren) both_cnt++;
        if (int'(tx_level) > peak) peak = int'(tx_level);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        wen_cyc.delete();
        wen_addr.delete();
        wen_data.delete();
        ren_cyc.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request; hold > 0 keeps resp_ready low for that many response cycles.
    task automatic do_req(input logic wen, input logic [7:0] addr, input logic [7:0] data,
                          input int hold, output logic [7:0] rdata, output int acc_c,
                          output int resp_c, output int stalls, output int bad);
        int n;
        stalls = 0; bad = 0; acc_c = -1; resp_c = -1; rdata = 8'h00;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = data;
        resp_ready = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin
            stalls++; n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check_val("req_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        acc_c = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!resp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!resp_valid) begin
            check_val("resp_timeout", 0, 1);
            resp_ready = 1'b1;
            return;
        end
        resp_c = cyc;
        rdata  = resp_rdata;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rdata || req_ready) bad++;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rd;
        int acc, rsp, st, bad, tot_st, order_err, n_before;

        reset = 1'b1; req_valid = 1'b0; req_wen = 1'b1; req_addr = 8'h00;
        req_wdata = 8'h00; resp_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_outs", {resp_valid, resp_rdata, uart_wen, uart_waddr, uart_wdata,
                               uart_ren, uart_raddr}, 0);
        check_val("rst_level", tx_level, 0);
        reset = 1'b0;
        #1;
        check_val("idle_thr_ready", req_ready, 1);

        // Single THR write
        clear_logs();
        do_req(1'b1, 8'h00, 8'h41, 0, rd, acc, rsp, st, bad);
        check_val("thr_ack_lat", rsp - acc, 1);
        check_val("thr_ack_data", rd, 0);
        wait_cyc(10);
        check_val("thr_pulse_cnt", wen_cyc.size(), 1);
        check_val("thr_pulse", {wen_addr[0], wen_data[0]}, 16'h0041);
        check_val("thr_level_end", tx_level, 0);

        // Burst of three, paced 5 cycles apart
        clear_logs();
        for (int k = 0; k < 3; k++) do_req(1'b1, 8'h00, 8'h61 + 8'(k), 0, rd, acc, rsp, st, bad);
        wait_cyc(20);
        check_val("burst_cnt", wen_cyc.size(), 3);
        for (int k = 0; k < 3; k++) check_val($sformatf("burst_data%0d", k), wen_data[k], 8'h61 + 8'(k));
        check_val("burst_gap01", wen_cyc[1] - wen_cyc[0], 5);
        check_val("burst_gap12", wen_cyc[2] - wen_cyc[1], 5);

        // Fill the FIFO: 14 writes, level peaks at 8 and the 14th stalls one cycle
        clear_logs();
        peak = 0; tot_st = 0;
        for (int k = 0; k < 14; k++) begin
            do_req(1'b1, 8'h00, 8'h80 + 8'(k), 0, rd, acc, rsp, st, bad);
            tot_st += st;
        end
        wait_cyc(80);
        check_val("full_peak", peak, 8);
        check_val("full_stalls", tot_st, 1);
        check_val("full_cnt", wen_cyc.size(), 14);
        order_err = 0;
        for (int k = 0; k < wen_data.size(); k++) if (wen_data[k] !== 8'h80 + 8'(k)) order_err++;
        check_val("full_order", order_err, 0);

        // Non-THR write goes straight out in the handshake cycle
        clear_logs();
        do_req(1'b1, 8'h03, 8'h5A, 0, rd, acc, rsp, st, bad);
        check_val("dwr_cnt", wen_cyc.size(), 1);
        check_val("dwr_same_cycle", wen_cyc[0] - acc, 0);
        check_val("dwr_pulse", {wen_addr[0], wen_data[0]}, 16'h035A);
        check_val("dwr_ack", {rd, 32'(rsp - acc)}, {8'h00, 32'd1});

        // LSR read with two bytes queued
        clear_logs();
        do_req(1'b1, 8'h00, 8'h11, 0, rd, acc, rsp, st, bad);
        do_req(1'b1, 8'h00, 8'h22, 0, rd, acc, rsp, st, bad);
        do_req(1'b0, 8'h05, 8'h00, 0, rd, acc, rsp, st, bad);
`ifdef UART_LSR_SYNTH_EN
        check_val("lsr_local_data", rd, 8'h00);
        check_val("lsr_local_lat", rsp - acc, 1);
        check_val("lsr_no_ren", ren_cyc.size(), 0);
`else
        check_val("lsr_data", rd, 8'h60);
        check_val("lsr_ren_cnt", ren_cyc.size(), 1);
        check_val("lsr_after_drain", ren_cyc[0] > wen_cyc[1], 1);
        check_val("lsr_lat", rsp - ren_cyc[0], 2);
`endif
        wait_cyc(10);
        do_req(1'b0, 8'h05, 8'h00, 0, rd, acc, rsp, st, bad);
        check_val("lsr_drained", rd, 8'h60);

        // Response held for 10 cycles after a read
        clear_logs();
        do_req(1'b0, 8'h02, 8'h00, 10, rd, acc, rsp, st, bad);
        check_val("hold_rd_data", rd, 8'hA5);
        check_val("hold_rd_stable", bad, 0);

        // Response held on a THR ack while queued bytes keep draining
        clear_logs();
        do_req(1'b1, 8'h00, 8'h31, 0, rd, acc, rsp, st, bad);
        do_req(1'b1, 8'h00, 8'h32, 0, rd, acc, rsp, st, bad);
        do_req(1'b1, 8'h00, 8'h33, 10, rd, acc, rsp, st, bad);
        check_val("hold_wr_stable", bad, 0);
        check_val("hold_wr_cnt", wen_cyc.size(), 3);
        check_val("hold_wr_during", wen_cyc[2] < rsp + 10, 1);
        check_val("hold_wr_data", {wen_data[0], wen_data[1], wen_data[2]}, 24'h313233);

        // Reset during RD_WAIT
        wait_cyc(10);
        clear_logs();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 8'h02; resp_ready = 1'b1;
        @(negedge clk);
        check_val("rdw_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_val("rdw_rst_outs", {req_ready, resp_valid, resp_rdata, uart_wen, uart_ren, tx_level}, 0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(10);
        check_val("rdw_no_resp", resp_valid, 0);
        check_val("rdw_ren_cnt", ren_cyc.size(), 1);

        // Reset with bytes queued mid-drain
        clear_logs();
        for (int k = 0; k < 4; k++) do_req(1'b1, 8'h00, 8'hA1 + 8'(k), 0, rd, acc, rsp, st, bad);
        check_val("drn_level", tx_level, 2);
        #2 reset = 1'b1;
        #1;
        check_val("drn_rst_level", tx_level, 0);
        check_val("drn_rst_outs", {req_ready, resp_valid, uart_wen, uart_waddr, uart_wdata, uart_ren}, 0);
        wait_cyc(2);
        reset = 1'b0;
        n_before = wen_cyc.size();
        wait_cyc(20);
        check_val("drn_pre_cnt", n_before, 2);
        check_val("drn_no_more", wen_cyc.size(), 2);

        check_val("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
